keypad_scanner: RTL and testbench

Matrix-scanning front end for the 4x3 game keypad. Drives one column at a time, samples the row lines, and debounces complete scans. Produces the level-held `Keypad[9:0]` / `KeypadHash` vector consumed by the game top level, plus a one-cycle new-press strobe with a key code. Sits between the board keypad pins and the top-level key-trigger logic.

---
 rtl/keypad_pkg.sv | 33 +++
 rtl/keypad_scanner_if.sv | 39 +++
 rtl/keypad_scanner.sv | 142 ++++++++++++++
 tb/tb_keypad_scanner.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared matrix geometry, special key codes and the mapping
//                from raw matrix index (row*3 + col) to key code.
//  Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  // Rows 0..2 hold digits 1..9 in reading order; row 3 is '*', '0', '#'.
  function automatic logic [3:0] raw_to_code(input logic [3:0] idx);
    logic [3:0] code;
    if (idx < 4'd9) begin
      code = idx + 4'd1;
    end else if (idx == 4'd9) begin
      code = KEY_STAR;
    end else if (idx == 4'd10) begin
      code = 4'd0;
    end else begin
      code = KEY_HASH;
    end
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner_if
//  Description : Keypad pin and key-report bundle. The slave side is the
//                scanner; the master side is the board/game top level.
//  Revision    : 1.0 - initial release
// ============================================================================
interface keypad_scanner_if;

  logic [3:0] Row;
  logic [2:0] Col;
  logic [9:0] Keypad;
  logic       KeypadStar;
  logic       KeypadHash;
  logic       KeyStrobe;
  logic [3:0] KeyCode;

  modport master (
    output Row,
    input  Col,
    input  Keypad,
    input  KeypadStar,
    input  KeypadHash,
    input  KeyStrobe,
    input  KeyCode
  );

  modport slave (
    input  Row,
    output Col,
    output Keypad,
    output KeypadStar,
    output KeypadHash,
    output KeyStrobe,
    output KeyCode
  );

endinterface
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : 4x3 matrix keypad scanner. Drives one column per dwell
//                period, samples synchronized rows, debounces whole scans
//                and reports held keys plus a new-press strobe/code.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  wire logic         CLK,
  input  wire logic         RST,
  keypad_scanner_if.slave   kp
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  logic [3:0]          row_meta_q, row_meta_d;
  logic [3:0]          row_sync_q, row_sync_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [1:0]          col_idx_q, col_idx_d;
  logic [NUM_KEYS-1:0] raw_q, raw_d;
  logic [NUM_KEYS-1:0] prev_q, prev_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_KEYS-1:0] deb_q, deb_d;
  logic                strobe_q, strobe_d;
  logic [3:0]          code_q, code_d;

  logic                dwell_end;
  logic                scan_end;
  logic [NUM_KEYS-1:0] snap;
  logic [NUM_KEYS-1:0] new_keys;
  logic [3:0]          bit_idx;

  // Lowest set code wins when several keys appear in the same update.
  function automatic logic [3:0] lowest_code(input logic [NUM_KEYS-1:0] v);
    logic [3:0] res;
    res = 4'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[4'(i)]) begin
        res = 4'(i);
      end
    end
    return res;
  endfunction

  // Next-state: synchronizer, column divider, raw capture and scan debounce.
  // prev/deb are kept in key-code order so outputs are direct slices.
  always_comb begin
    row_meta_d = kp.Row;
    row_sync_d = row_meta_q;
    div_d      = div_q;
    col_idx_d  = col_idx_q;
    raw_d      = raw_q;
    prev_d     = prev_q;
    cnt_d      = cnt_q;
    deb_d      = deb_q;
    strobe_d   = 1'b0;
    code_d     = code_q;
    snap       = '0;
    new_keys   = '0;
    bit_idx    = 4'd0;

    dwell_end = (div_q == DIV_W'(SCAN_DIV - 1));
    scan_end  = dwell_end && (col_idx_q == 2'd2);

    if (dwell_end) begin
      div_d     = '0;
      col_idx_d = (col_idx_q == 2'd2) ? 2'd0 : col_idx_q + 2'd1;
      for (int r = 0; r < NUM_ROWS; r++) begin
        bit_idx        = 4'(r * NUM_COLS) + 4'(col_idx_q);
        raw_d[bit_idx] = row_sync_q[r];
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    // raw_d already holds this cycle's column-2 rows, so it is the full scan.
    for (int i = 0; i < NUM_KEYS; i++) begin
      snap[raw_to_code(4'(i))] = raw_d[4'(i)];
    end

    if (scan_end) begin
      if (snap != prev_q) begin
        prev_d = snap;
        cnt_d  = CNT_W'(1);
      end else if (cnt_q != CNT_W'(DEBOUNCE_SCANS)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end

      if ((cnt_d == CNT_W'(DEBOUNCE_SCANS)) && (snap != deb_q)) begin
        deb_d    = snap;
        new_keys = snap & ~deb_q;
        if (new_keys != '0) begin
          strobe_d = 1'b1;
          code_d   = lowest_code(new_keys);
        end
      end
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      row_meta_q <= '0;
      row_sync_q <= '0;
      div_q      <= '0;
      col_idx_q  <= '0;
      raw_q      <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      deb_q      <= '0;
      strobe_q   <= 1'b0;
      code_q     <= '0;
    end else begin
      row_meta_q <= row_meta_d;
      row_sync_q <= row_sync_d;
      div_q      <= div_d;
      col_idx_q  <= col_idx_d;
      raw_q      <= raw_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      deb_q      <= deb_d;
      strobe_q   <= strobe_d;
      code_q     <= code_d;
    end
  end

  assign kp.Col        = 3'b001 << col_idx_q;
  assign kp.Keypad     = deb_q[9:0];
  assign kp.KeypadStar = deb_q[KEY_STAR];
  assign kp.KeypadHash = deb_q[KEY_HASH];
  assign kp.KeyStrobe  = strobe_q;
  assign kp.KeyCode    = code_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scanner
//  Description : Directed bench for keypad_scanner with a behavioural
//                switch-matrix model (SCAN_DIV = 4, DEBOUNCE_SCANS = 3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  logic        CLK;
  logic        RST;
  logic [11:0] pressed;   // indexed by raw matrix position row*3+col
  logic [3:0]  row_model;
  int          n_checks;
  int          n_errors;
  int          strobes;
  logic [3:0]  scode;

  keypad_scanner_if kp ();

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .kp  (kp)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Closed switch connects the driven column to its row line.
  always_comb begin
    row_model = 4'b0000;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (kp.Col[c] && pressed[r * 3 + c]) begin
          row_model[r] = 1'b1;
        end
      end
    end
  end
  assign kp.Row = row_model;

  function automatic int raw_of(input int key);
    if (key >= 1 && key <= 9) return key - 1;
    if (key == 0)  return 10;
    if (key == 10) return 9;
    return 11;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one full scan from an aligned point, counting strobe pulses.
  task automatic next_scan(output int nst, output logic [3:0] code);
    logic last;
    nst  = 0;
    code = 4'd0;
    last = 1'b0;
    repeat (12) begin
      @(negedge CLK);
      if (kp.KeyStrobe === 1'b1) begin
        nst++;
        code = kp.KeyCode;
        if (last) nst = 99;
      end
      last = (kp.KeyStrobe === 1'b1);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    pressed  = '0;
    RST      = 1'b1;
    repeat (2) @(negedge CLK);

    chk("rst_col",    32'(kp.Col), 32'h1);
    chk("rst_keypad", 32'(kp.Keypad), 32'h0);
    chk("rst_star",   32'(kp.KeypadStar), 32'h0);
    chk("rst_hash",   32'(kp.KeypadHash), 32'h0);
    chk("rst_strobe", 32'(kp.KeyStrobe), 32'h0);
    chk("rst_code",   32'(kp.KeyCode), 32'h0);

    RST = 1'b0;
    chk("col_seq_0", 32'(kp.Col), 32'h1);
    for (int k = 1; k < 16; k++) begin
      @(negedge CLK);
      chk($sformatf("col_seq_%0d", k), 32'(kp.Col), 32'(1 << ((k / 4) % 3)));
    end
    repeat (9) @(negedge CLK);

    next_scan(strobes, scode);
    chk("idle_keypad", 32'(kp.Keypad), 32'h0);
    chk("idle_strobes", 32'(strobes), 32'd0);

    // Hold '5'
    pressed[raw_of(5)] = 1'b1;
    next_scan(strobes, scode);
    chk("k5_scan1", 32'(kp.Keypad), 32'h0);
    next_scan(strobes, scode);
    chk("k5_scan2", 32'(kp.Keypad), 32'h0);
    next_scan(strobes, scode);
    chk("k5_scan3", 32'(kp.Keypad), 32'h020);
    chk("k5_strobes", 32'(strobes), 32'd1);
    chk("k5_code", 32'(scode), 32'd5);
    next_scan(strobes, scode);
    chk("k5_held_strobes", 32'(strobes), 32'd0);
    pressed = '0;
    next_scan(strobes, scode);
    chk("k5_rel1", 32'(kp.Keypad), 32'h020);
    next_scan(strobes, scode);
    chk("k5_rel2", 32'(kp.Keypad), 32'h020);
    next_scan(strobes, scode);
    chk("k5_rel3", 32'(kp.Keypad), 32'h0);
    chk("k5_rel_strobes", 32'(strobes), 32'd0);
    chk("k5_code_hold", 32'(kp.KeyCode), 32'd5);

    // Bouncing '8'
    pressed[raw_of(8)] = 1'b1;
    next_scan(strobes, scode);
    chk("b8_scan1", 32'(kp.Keypad), 32'h0);
    pressed = '0;
    next_scan(strobes, scode);
    chk("b8_scan2", 32'(kp.Keypad), 32'h0);
    pressed[raw_of(8)] = 1'b1;
    next_scan(strobes, scode);
    chk("b8_scan3", 32'(kp.Keypad), 32'h0);
    next_scan(strobes, scode);
    chk("b8_scan4", 32'(kp.Keypad), 32'h0);
    next_scan(strobes, scode);
    chk("b8_scan5", 32'(kp.Keypad), 32'h100);
    chk("b8_strobes", 32'(strobes), 32'd1);
    chk("b8_code", 32'(scode), 32'd8);
    pressed = '0;
    repeat (3) next_scan(strobes, scode);
    chk("b8_rel", 32'(kp.Keypad), 32'h0);

    // '3' and '#' together
    pressed[raw_of(3)]  = 1'b1;
    pressed[raw_of(11)] = 1'b1;
    next_scan(strobes, scode);
    next_scan(strobes, scode);
    chk("k3h_scan2_keypad", 32'(kp.Keypad), 32'h0);
    chk("k3h_scan2_hash", 32'(kp.KeypadHash), 32'h0);
    next_scan(strobes, scode);
    chk("k3h_keypad", 32'(kp.Keypad), 32'h008);
    chk("k3h_hash", 32'(kp.KeypadHash), 32'h1);
    chk("k3h_star", 32'(kp.KeypadStar), 32'h0);
    chk("k3h_strobes", 32'(strobes), 32'd1);
    chk("k3h_code", 32'(scode), 32'd3);
    pressed = '0;
    repeat (3) next_scan(strobes, scode);
    chk("k3h_rel_hash", 32'(kp.KeypadHash), 32'h0);
    chk("k3h_rel_strobes", 32'(strobes), 32'd0);

    // Hold '7', then add '0'
    pressed[raw_of(7)] = 1'b1;
    repeat (3) next_scan(strobes, scode);
    chk("k7_keypad", 32'(kp.Keypad), 32'h080);
    chk("k7_code", 32'(scode), 32'd7);
    pressed[raw_of(0)] = 1'b1;
    next_scan(strobes, scode);
    chk("k70_scan1", 32'(kp.Keypad), 32'h080);
    next_scan(strobes, scode);
    chk("k70_scan2", 32'(kp.Keypad), 32'h080);
    next_scan(strobes, scode);
    chk("k70_keypad", 32'(kp.Keypad), 32'h081);
    chk("k70_strobes", 32'(strobes), 32'd1);
    chk("k70_code", 32'(scode), 32'd0);
    pressed = '0;
    repeat (3) next_scan(strobes, scode);
    chk("k70_rel", 32'(kp.Keypad), 32'h0);

    // '1' debounced, then reset in the middle of column 1
    pressed[raw_of(1)] = 1'b1;
    repeat (3) next_scan(strobes, scode);
    chk("k1_keypad", 32'(kp.Keypad), 32'h002);
    chk("k1_code", 32'(scode), 32'd1);
    repeat (6) @(negedge CLK);
    chk("k1_mid_col", 32'(kp.Col), 32'h2);
    RST = 1'b1;
    #1;
    chk("mid_rst_keypad", 32'(kp.Keypad), 32'h0);
    chk("mid_rst_col", 32'(kp.Col), 32'h1);
    chk("mid_rst_code", 32'(kp.KeyCode), 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    next_scan(strobes, scode);
    chk("k1_re_scan1", 32'(kp.Keypad), 32'h0);
    next_scan(strobes, scode);
    chk("k1_re_scan2", 32'(kp.Keypad), 32'h0);
    next_scan(strobes, scode);
    chk("k1_re_keypad", 32'(kp.Keypad), 32'h002);
    chk("k1_re_strobes", 32'(strobes), 32'd1);
    chk("k1_re_code", 32'(scode), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
